sat_bin_loader: RTL

- Hardware replacement for the bench-side bin load sequence in front of `sat_bin`.
- Accepts a job header, then independent clause and variable word streams. Writes them into `sat_bin`'s external RAM ports and zero-initialises var-state and lvl-state entries.
- Issues the start/bin-info pulse, waits for `done`, and returns the SAT/UNSAT verdict. Generalises the load step with parametrised bin geometry, back-pressure, size checking and abort.

---
 rtl/sat_bin_loader_if.sv | 86 ++++++++
 rtl/sat_bin_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sat_bin_loader_if.sv
// rtl/sat_bin_loader_if.sv - job, stream, RAM and result signals between a job source and sat_bin_loader
//
// Groups every non-clock/reset signal of sat_bin_loader.
//   slave  : the loader (job/stream/done inputs, RAM/start/result outputs)
//   master : the job source / sat_bin side that drives the loader inputs
// Signals:
//   cfg_valid_i/cfg_ready_o/cfg_nb_i/cfg_nv_i  job header handshake
//   c_valid_i/c_ready_o/c_data_i               clause word stream
//   v_valid_i/v_ready_o/v_data_i               variable word stream
//   abort_i                                    cancel current job
//   apply_ex_o, ram_*_ex_o                     external RAM write ports of sat_bin
//   start_o/bin_info_en_o/nb_all_o/nv_all_o    start pulse and job size
//   done_i/global_sat_i/global_unsat_i         sat_bin completion
//   busy_o, result_*_o, err_o                  status and verdict
interface sat_bin_loader_if #(
    parameter int NUM_VARS_A_BIN     = 8,
    parameter int WIDTH_CLAUSES      = NUM_VARS_A_BIN * 2,
    parameter int WIDTH_VAR          = 12,
    parameter int WIDTH_VAR_STATES   = 19,
    parameter int WIDTH_LVL_STATES   = 11,
    parameter int ADDR_WIDTH_CLAUSES = 9,
    parameter int ADDR_WIDTH_VAR     = 9
);
    logic                          cfg_valid_i;
    logic                          cfg_ready_o;
    logic [WIDTH_CLAUSES-1:0]      cfg_nb_i;
    logic [WIDTH_VAR-1:0]          cfg_nv_i;
    logic                          c_valid_i;
    logic                          c_ready_o;
    logic [WIDTH_CLAUSES-1:0]      c_data_i;
    logic                          v_valid_i;
    logic                          v_ready_o;
    logic [WIDTH_VAR-1:0]          v_data_i;
    logic                          abort_i;
    logic                          apply_ex_o;
    logic                          ram_we_c_ex_o;
    logic [WIDTH_CLAUSES-1:0]      ram_din_c_ex_o;
    logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_c_ex_o;
    logic                          ram_we_v_ex_o;
    logic [WIDTH_VAR-1:0]          ram_din_v_ex_o;
    logic [ADDR_WIDTH_VAR-1:0]     ram_addr_v_ex_o;
    logic                          ram_we_vs_ex_o;
    logic [WIDTH_VAR_STATES-1:0]   ram_din_vs_ex_o;
    logic [ADDR_WIDTH_VAR-1:0]     ram_addr_vs_ex_o;
    logic                          ram_we_ls_ex_o;
    logic [WIDTH_LVL_STATES-1:0]   ram_din_ls_ex_o;
    logic [ADDR_WIDTH_VAR-1:0]     ram_addr_ls_ex_o;
    logic                          start_o;
    logic                          bin_info_en_o;
    logic [WIDTH_CLAUSES-1:0]      nb_all_o;
    logic [WIDTH_VAR-1:0]          nv_all_o;
    logic                          done_i;
    logic                          global_sat_i;
    logic                          global_unsat_i;
    logic                          busy_o;
    logic                          result_valid_o;
    logic                          result_sat_o;
    logic                          result_unsat_o;
    logic                          err_o;

    modport slave (
        input  cfg_valid_i, cfg_nb_i, cfg_nv_i,
        input  c_valid_i, c_data_i, v_valid_i, v_data_i, abort_i,
        input  done_i, global_sat_i, global_unsat_i,
        output cfg_ready_o, c_ready_o, v_ready_o, apply_ex_o,
        output ram_we_c_ex_o, ram_din_c_ex_o, ram_addr_c_ex_o,
        output ram_we_v_ex_o, ram_din_v_ex_o, ram_addr_v_ex_o,
        output ram_we_vs_ex_o, ram_din_vs_ex_o, ram_addr_vs_ex_o,
        output ram_we_ls_ex_o, ram_din_ls_ex_o, ram_addr_ls_ex_o,
        output start_o, bin_info_en_o, nb_all_o, nv_all_o,
        output busy_o, result_valid_o, result_sat_o, result_unsat_o, err_o
    );

    modport master (
        output cfg_valid_i, cfg_nb_i, cfg_nv_i,
        output c_valid_i, c_data_i, v_valid_i, v_data_i, abort_i,
        output done_i, global_sat_i, global_unsat_i,
        input  cfg_ready_o, c_ready_o, v_ready_o, apply_ex_o,
        input  ram_we_c_ex_o, ram_din_c_ex_o, ram_addr_c_ex_o,
        input  ram_we_v_ex_o, ram_din_v_ex_o, ram_addr_v_ex_o,
        input  ram_we_vs_ex_o, ram_din_vs_ex_o, ram_addr_vs_ex_o,
        input  ram_we_ls_ex_o, ram_din_ls_ex_o, ram_addr_ls_ex_o,
        input  start_o, bin_info_en_o, nb_all_o, nv_all_o,
        input  busy_o, result_valid_o, result_sat_o, result_unsat_o, err_o
    );
endinterface

// File: rtl/sat_bin_loader.sv
// rtl/sat_bin_loader.sv - loads sat_bin external RAMs from clause/var streams, starts it and returns the verdict
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  sat_bin_loader_if.slave: header, clause/var streams, abort, sat_bin RAM
//        write ports, start/job size, done/result, busy and error pulse
// Every output is a register; the combinational block computes the next state
// and the next value of every output, so readies and strobes follow the
// state they belong to without an extra cycle of lag.
module sat_bin_loader #(
    parameter int NUM_VARS_A_BIN     = 8,
    parameter int CMAX               = 8,
    parameter int VMAX               = 8,
    parameter int WIDTH_CLAUSES      = NUM_VARS_A_BIN * 2,
    parameter int WIDTH_VAR          = 12,
    parameter int WIDTH_VAR_STATES   = 19,
    parameter int WIDTH_LVL_STATES   = 11,
    parameter int ADDR_WIDTH_CLAUSES = 9,
    parameter int ADDR_WIDTH_VAR     = 9
) (
    input logic            clk,
    input logic            rst,
    sat_bin_loader_if.slave bus
);
    localparam int CCW = ADDR_WIDTH_CLAUSES + 1;
    localparam int VCW = ADDR_WIDTH_VAR + 1;
    // wide enough that nb*CMAX / nb*VMAX can never overflow before the range check
    localparam int PW  = WIDTH_CLAUSES + 32;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_START, S_RUN} state_t;

    state_t                       state, state_n;
    logic [CCW-1:0]               ccnt, ccnt_n, ctot, ctot_n, cnext;
    logic [VCW-1:0]               vcnt, vcnt_n, vtot, vtot_n, vnext;
    logic [WIDTH_CLAUSES-1:0]     nb_q, nb_n;
    logic [WIDTH_VAR-1:0]         nv_q, nv_n;
    logic [PW-1:0]                ctot_full, vtot_full;
    logic                         hdr_bad, c_fire, v_fire;
    logic                         we_c_n, we_v_n, err_n, rv_n, sat_n, unsat_n;
    logic [WIDTH_CLAUSES-1:0]     din_c_n;
    logic [ADDR_WIDTH_CLAUSES-1:0] addr_c_n;
    logic [WIDTH_VAR-1:0]         din_v_n;
    logic [ADDR_WIDTH_VAR-1:0]    addr_v_n;

    assign ctot_full = PW'(bus.cfg_nb_i) * PW'(CMAX);
    assign vtot_full = PW'(bus.cfg_nb_i) * PW'(VMAX);
    assign hdr_bad   = (bus.cfg_nb_i == '0)
                    || (ctot_full > PW'(2**ADDR_WIDTH_CLAUSES - 1))
                    || (vtot_full > PW'(2**ADDR_WIDTH_VAR - 1));

    assign c_fire = bus.c_valid_i && bus.c_ready_o;
    assign v_fire = bus.v_valid_i && bus.v_ready_o;
    // RAM slots start at 1: address 0 is reserved inside sat_bin
    assign cnext  = ccnt + CCW'(1);
    assign vnext  = vcnt + VCW'(1);

    always_comb begin
        state_n  = state;
        ccnt_n   = ccnt;
        vcnt_n   = vcnt;
        ctot_n   = ctot;
        vtot_n   = vtot;
        nb_n     = nb_q;
        nv_n     = nv_q;
        we_c_n   = 1'b0;
        din_c_n  = bus.ram_din_c_ex_o;
        addr_c_n = bus.ram_addr_c_ex_o;
        we_v_n   = 1'b0;
        din_v_n  = bus.ram_din_v_ex_o;
        addr_v_n = bus.ram_addr_v_ex_o;
        err_n    = 1'b0;
        rv_n     = 1'b0;
        sat_n    = bus.result_sat_o;
        unsat_n  = bus.result_unsat_o;

        unique case (state)
            S_IDLE: begin
                if (bus.cfg_valid_i && bus.cfg_ready_o) begin
                    if (hdr_bad) begin
                        err_n = 1'b1;
                    end else begin
                        nb_n    = bus.cfg_nb_i;
                        nv_n    = bus.cfg_nv_i;
                        ctot_n  = ctot_full[CCW-1:0];
                        vtot_n  = vtot_full[VCW-1:0];
                        ccnt_n  = '0;
                        vcnt_n  = '0;
                        state_n = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.abort_i) begin
                    // a word handshaking together with abort is dropped
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    if (c_fire) begin
                        we_c_n   = 1'b1;
                        din_c_n  = bus.c_data_i;
                        addr_c_n = cnext[ADDR_WIDTH_CLAUSES-1:0];
                        ccnt_n   = cnext;
                    end
                    if (v_fire) begin
                        we_v_n   = 1'b1;
                        din_v_n  = bus.v_data_i;
                        addr_v_n = vnext[ADDR_WIDTH_VAR-1:0];
                        vcnt_n   = vnext;
                    end
                    if (ccnt_n == ctot && vcnt_n == vtot) begin
                        state_n = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (bus.abort_i) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bus.abort_i) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort_i) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else if (bus.done_i) begin
                    rv_n    = 1'b1;
                    sat_n   = bus.global_sat_i;
                    unsat_n = bus.global_unsat_i;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            ccnt                 <= '0;
            vcnt                 <= '0;
            ctot                 <= '0;
            vtot                 <= '0;
            nb_q                 <= '0;
            nv_q                 <= '0;
            bus.cfg_ready_o      <= 1'b1;
            bus.c_ready_o        <= 1'b0;
            bus.v_ready_o        <= 1'b0;
            bus.apply_ex_o       <= 1'b0;
            bus.ram_we_c_ex_o    <= 1'b0;
            bus.ram_din_c_ex_o   <= '0;
            bus.ram_addr_c_ex_o  <= '0;
            bus.ram_we_v_ex_o    <= 1'b0;
            bus.ram_din_v_ex_o   <= '0;
            bus.ram_addr_v_ex_o  <= '0;
            bus.ram_we_vs_ex_o   <= 1'b0;
            bus.ram_din_vs_ex_o  <= '0;
            bus.ram_addr_vs_ex_o <= '0;
            bus.ram_we_ls_ex_o   <= 1'b0;
            bus.ram_din_ls_ex_o  <= '0;
            bus.ram_addr_ls_ex_o <= '0;
            bus.start_o          <= 1'b0;
            bus.bin_info_en_o    <= 1'b0;
            bus.nb_all_o         <= '0;
            bus.nv_all_o         <= '0;
            bus.busy_o           <= 1'b0;
            bus.result_valid_o   <= 1'b0;
            bus.result_sat_o     <= 1'b0;
            bus.result_unsat_o   <= 1'b0;
            bus.err_o            <= 1'b0;
        end else begin
            state                <= state_n;
            ccnt                 <= ccnt_n;
            vcnt                 <= vcnt_n;
            ctot                 <= ctot_n;
            vtot                 <= vtot_n;
            nb_q                 <= nb_n;
            nv_q                 <= nv_n;
            bus.cfg_ready_o      <= (state_n == S_IDLE);
            bus.c_ready_o        <= (state_n == S_LOAD) && (ccnt_n < ctot_n);
            bus.v_ready_o        <= (state_n == S_LOAD) && (vcnt_n < vtot_n);
            bus.apply_ex_o       <= (state_n == S_LOAD) || (state_n == S_FLUSH);
            bus.ram_we_c_ex_o    <= we_c_n;
            bus.ram_din_c_ex_o   <= din_c_n;
            bus.ram_addr_c_ex_o  <= addr_c_n;
            // var, var-state and lvl-state entries share one address per word
            bus.ram_we_v_ex_o    <= we_v_n;
            bus.ram_din_v_ex_o   <= din_v_n;
            bus.ram_addr_v_ex_o  <= addr_v_n;
            bus.ram_we_vs_ex_o   <= we_v_n;
            bus.ram_din_vs_ex_o  <= '0;
            bus.ram_addr_vs_ex_o <= addr_v_n;
            bus.ram_we_ls_ex_o   <= we_v_n;
            bus.ram_din_ls_ex_o  <= '0;
            bus.ram_addr_ls_ex_o <= addr_v_n;
            bus.start_o          <= (state_n == S_START);
            bus.bin_info_en_o    <= (state_n == S_START);
            bus.nb_all_o         <= (state_n == S_START) ? nb_n : '0;
            bus.nv_all_o         <= (state_n == S_START) ? nv_n : '0;
            bus.busy_o           <= (state_n != S_IDLE);
            bus.result_valid_o   <= rv_n;
            bus.result_sat_o     <= sat_n;
            bus.result_unsat_o   <= unsat_n;
            bus.err_o            <= err_n;
        end
    end
endmodule
